// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks E/M/W writer records and the HI/LO busy counter to drive stall and D-stage forwarding selects
module hazard_scoreboard #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int TUSE_NONE   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [2:0] d_tuse_rs,
  input  logic [2:0] d_tuse_rt,
  input  logic [4:0] d_a3,
  input  logic [1:0] d_tnew,
  input  logic       d_is_md,
  input  logic       e_md_start,
  input  logic       e_md_div,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy
);
  localparam logic [2:0] TN = 3'(TUSE_NONE);
  logic [4:0] e_a3_q, e_a3_d, m_a3_q, m_a3_d, w_a3_q, w_a3_d;
  logic [1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       stall_rs, stall_rt, stall_md;

  function automatic logic hit(input logic [4:0] a3, input logic [4:0] r);
    return a3 != 5'd0 && a3 == r;
  endfunction

  function automatic logic op_stall(input logic [4:0] r, input logic [2:0] tuse,
                                    input logic [4:0] ea, input logic [1:0] et,
                                    input logic [4:0] ma, input logic [1:0] mt);
    return tuse != TN && ((hit(ea, r) && {1'b0, et} > tuse) || (hit(ma, r) && {1'b0, mt} > tuse));
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] r,
                                     input logic [4:0] ea, input logic [1:0] et,
                                     input logic [4:0] ma, input logic [1:0] mt,
                                     input logic [4:0] wa, input logic [1:0] wt);
    return hit(ea, r) ? (et == 2'd0 ? 2'd1 : 2'd0) :
           hit(ma, r) ? (mt == 2'd0 ? 2'd2 : 2'd0) :
           hit(wa, r) ? (wt == 2'd0 ? 2'd3 : 2'd0) : 2'd0;
  endfunction

  // stall and forwarding decisions from current records and the D-stage operands
  always_comb begin
    stall_rs   = d_valid && op_stall(d_rs, d_tuse_rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
    stall_rt   = d_valid && op_stall(d_rt, d_tuse_rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
    stall_md   = d_valid && d_is_md && (md_cnt_q != 4'd0 || e_md_start);
    stall      = stall_rs || stall_rt || stall_md;
    fwd_rs_sel = fwd(d_rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q, w_tnew_q);
    fwd_rt_sel = fwd(d_rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q, w_tnew_q);
    md_busy    = md_cnt_q != 4'd0;
  end

  // next records: a stalled or empty D slot enters E as a bubble; tnew counts down as the writer ages
  always_comb begin
    e_a3_d   = (d_valid && !stall) ? d_a3 : 5'd0;
    e_tnew_d = (d_valid && !stall) ? d_tnew : 2'd0;
    m_a3_d   = e_a3_q;
    m_tnew_d = e_tnew_q != 2'd0 ? e_tnew_q - 2'd1 : 2'd0;
    w_a3_d   = m_a3_q;
    w_tnew_d = 2'd0;
    md_cnt_d = md_cnt_q != 4'd0 ? md_cnt_q - 4'd1 :
               e_md_start ? (e_md_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) : 4'd0;
  end

  // state registers; reset overrides any start or countdown
  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      m_a3_q   <= 5'd0;
      m_tnew_q <= 2'd0;
      w_a3_q   <= 5'd0;
      w_tnew_q <= 2'd0;
      md_cnt_q <= 4'd0;
    end else begin
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      w_a3_q   <= w_a3_d;
      w_tnew_q <= w_tnew_d;
      md_cnt_q <= md_cnt_d;
    end
  end
endmodule
